// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//   Shared definitions for the multi-port register file.
//   - fsm_state_e : clear-engine state encoding (SWEEP / IDLE)
//   - ZERO_ADDR   : address of the hardwired-zero register
//   - slice_lo()  : low bit index of element idx inside a packed vector
//                   built from width-bit elements
//   Optional feature macro used by the design: REGFILE_BYPASS_EN
// -----------------------------------------------------------------------------
package regfile_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } fsm_state_e;

   localparam int ZERO_ADDR = 0;

   function automatic int slice_lo(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/regfile_rdport.sv
// -----------------------------------------------------------------------------
// regfile_rdport
//   One registered read port of the register file.
//   Build option: REGFILE_BYPASS_EN adds write-to-read forwarding.
//
// Ports:
//   clk       in   clock, rising edge
//   clear_n   in   asynchronous active-low reset
//   busy      in   clear engine sweeping; reads return zero
//   rd_req    in   read request for this port
//   rd_addr   in   read address for this port
//   mem_data  in   combinational array contents at rd_addr
//   wr_en     in   (bypass only) a real array write happens this cycle
//   wr_addr   in   (bypass only) write address
//   wr_data   in   (bypass only) write data
//   rd_data   out  registered read data, held when rd_req=0
//   rd_valid  out  rd_data was updated by the last edge
// -----------------------------------------------------------------------------
module regfile_rdport
   import regfile_pkg::*;
#(
   parameter int AWIDTH = 5,
   parameter int DWIDTH = 16
) (
   input  logic              clk,
   input  logic              clear_n,
   input  logic              busy,
   input  logic              rd_req,
   input  logic [AWIDTH-1:0] rd_addr,
   input  logic [DWIDTH-1:0] mem_data,
`ifdef REGFILE_BYPASS_EN
   input  logic              wr_en,
   input  logic [AWIDTH-1:0] wr_addr,
   input  logic [DWIDTH-1:0] wr_data,
`endif
   output logic [DWIDTH-1:0] rd_data,
   output logic              rd_valid
);

   logic [DWIDTH-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;

   always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = rd_req;
      if (rd_req) begin
         // Array is logically zero during a sweep, and entry 0 is hardwired.
         if (busy || (rd_addr == AWIDTH'(ZERO_ADDR))) begin
            rd_data_d = '0;
         end
`ifdef REGFILE_BYPASS_EN
         // wr_en already excludes busy and address 0, so only a real write
         // is forwarded.
         else if (wr_en && (wr_addr == rd_addr)) begin
            rd_data_d = wr_data;
         end
`endif
         else begin
            rd_data_d = mem_data;
         end
      end
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//   Parametrised register file with NRD independent registered read ports,
//   one write port, hardwired-zero entry 0 and a sequenced clear engine that
//   zeroes the array after reset and on request.
//   Build option: REGFILE_BYPASS_EN forwards same-cycle writes to reads.
//
// Ports:
//   clk       in   clock, rising edge
//   clear_n   in   asynchronous active-low reset
//   clear     in   one-cycle request to zero the whole array
//   rd_req    in   [NRD]            per-port read request
//   rd_addr   in   [NRD*AWIDTH]     packed read addresses
//   wr_req    in   write enable (ignored while busy)
//   wr_addr   in   [AWIDTH]         write address
//   wr_data   in   [DWIDTH]         write data
//   rd_data   out  [NRD*DWIDTH]     packed registered read data
//   rd_valid  out  [NRD]            per-port read-data-updated flag
//   busy      out  clear engine sweeping
// -----------------------------------------------------------------------------
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int AWIDTH = 5,
   parameter int DWIDTH = 16,
   parameter int NRD    = 2
) (
   input  logic                   clk,
   input  logic                   clear_n,
   input  logic                   clear,
   input  logic [NRD-1:0]         rd_req,
   input  logic [NRD*AWIDTH-1:0]  rd_addr,
   input  logic                   wr_req,
   input  logic [AWIDTH-1:0]      wr_addr,
   input  logic [DWIDTH-1:0]      wr_data,
   output logic [NRD*DWIDTH-1:0]  rd_data,
   output logic [NRD-1:0]         rd_valid,
   output logic                   busy
);

   localparam int DEPTH = 1 << AWIDTH;
   localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

   // Storage has no reset; the sweep is what zeroes it.
   logic [DWIDTH-1:0] mem [DEPTH];

   fsm_state_e        state_q, state_d;
   logic [AWIDTH-1:0] ptr_q, ptr_d;

   logic              wr_en;
   logic              mem_we;
   logic [AWIDTH-1:0] mem_waddr;
   logic [DWIDTH-1:0] mem_wdata;

   // ---------------------------------------------------------------------------
   // Clear engine
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      if (state_q == SWEEP) begin
         if (clear) begin
            ptr_d = '0;                 // a new request restarts the sweep
         end else if (ptr_q == LAST_ADDR) begin
            state_d = IDLE;
            ptr_d   = '0;
         end else begin
            ptr_d = ptr_q + AWIDTH'(1);
         end
      end else if (clear) begin
         state_d = SWEEP;
         ptr_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state_q <= SWEEP;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   assign busy = (state_q == SWEEP);

   // ---------------------------------------------------------------------------
   // Array write: the sweep owns the port while busy; a user write is also
   // dropped in the IDLE cycle that samples clear.
   // ---------------------------------------------------------------------------
   assign wr_en     = !busy && !clear && wr_req && (wr_addr != AWIDTH'(ZERO_ADDR));
   assign mem_we    = busy || wr_en;
   assign mem_waddr = busy ? ptr_q : wr_addr;
   assign mem_wdata = busy ? '0    : wr_data;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   // ---------------------------------------------------------------------------
   // Read ports
   // ---------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < NRD; gi++) begin : g_rd
         logic [AWIDTH-1:0] port_addr;
         logic [DWIDTH-1:0] port_mem_data;

         assign port_addr     = rd_addr[slice_lo(gi, AWIDTH) +: AWIDTH];
         assign port_mem_data = mem[port_addr];

         regfile_rdport #(
            .AWIDTH (AWIDTH),
            .DWIDTH (DWIDTH)
         ) u_rdport (
            .clk      (clk),
            .clear_n  (clear_n),
            .busy     (busy),
            .rd_req   (rd_req[gi]),
            .rd_addr  (port_addr),
            .mem_data (port_mem_data),
`ifdef REGFILE_BYPASS_EN
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
`endif
            .rd_data  (rd_data[slice_lo(gi, DWIDTH) +: DWIDTH]),
            .rd_valid (rd_valid[gi])
         );
      end
   endgenerate

endmodule
